// File: rtl/mac_pkg.sv
// Shared sizing defaults and IEEE-754 binary32 field constants for the synapse accumulator.
package mac_pkg;
  localparam int N_SYN  = 5;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int BIAS   = 127;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
endpackage

// File: rtl/fp32_adder.sv
// Combinational binary32 adder: round-to-nearest-even, subnormals flushed to +0,
// any NaN or Inf + -Inf gives the canonical quiet NaN, exact zero sums give +0.
module fp32_adder
  import mac_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);
  // hidden bit + mantissa + guard/round/sticky
  localparam int FW = MAN_W + 4;

  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge;

  assign {a_sign, a_exp, a_man} = a;
  assign {b_sign, b_exp, b_man} = b;
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == '1) && (a_man == '0);
  assign b_inf  = (b_exp == '1) && (b_man == '0);
  assign a_nan  = (a_exp == '1) && (a_man != '0);
  assign b_nan  = (b_exp == '1) && (b_man != '0);
  assign a_ge   = {a_exp, a_man} >= {b_exp, b_man};

  logic             l_sign, s_sign;
  logic [EXP_W-1:0] l_exp, s_exp, exp_diff;
  logic [MAN_W:0]   l_mant, s_mant;
  logic [FW-1:0]    l_ext, s_ext, s_mask, s_shift, mag_sub, norm;
  logic [FW:0]      mag_add;
  logic [4:0]       lz;
  logic [9:0]       exp_w;
  logic [MAN_W+1:0] rounded;
  logic             round_up, cancel;
  logic [31:0]      normal_sum;

  always_comb begin
    if (a_ge) begin
      l_sign = a_sign; l_exp = a_exp; l_mant = {1'b1, a_man};
      s_sign = b_sign; s_exp = b_exp; s_mant = {1'b1, b_man};
    end else begin
      l_sign = b_sign; l_exp = b_exp; l_mant = {1'b1, b_man};
      s_sign = a_sign; s_exp = a_exp; s_mant = {1'b1, a_man};
    end
    exp_diff = l_exp - s_exp;
  end

  // Align the smaller operand; bits shifted out collapse into the sticky bit.
  always_comb begin
    l_ext   = {l_mant, 3'b000};
    s_ext   = {s_mant, 3'b000};
    s_mask  = '0;
    s_shift = '0;
    if (exp_diff >= 8'(FW)) begin
      s_shift = {{(FW-1){1'b0}}, 1'b1};
    end else begin
      s_mask  = (FW'(1) << exp_diff) - FW'(1);
      s_shift = (s_ext >> exp_diff) | {{(FW-1){1'b0}}, |(s_ext & s_mask)};
    end
  end

  always_comb begin
    mag_add = {1'b0, l_ext} + {1'b0, s_shift};
    mag_sub = l_ext - s_shift;
    lz      = '0;
    norm    = '0;
    cancel  = 1'b0;
    exp_w   = {2'b00, l_exp};
    if (l_sign == s_sign) begin
      if (mag_add[FW]) begin
        norm  = {mag_add[FW:2], mag_add[1] | mag_add[0]};
        exp_w = exp_w + 10'd1;
      end else begin
        norm = mag_add[FW-1:0];
      end
    end else begin
      cancel = (mag_sub == '0);
      for (int i = 0; i < FW; i++) begin
        if (mag_sub[i]) lz = 5'(FW - 1 - i);
      end
      norm  = mag_sub << lz;
      exp_w = exp_w - {5'b0, lz};
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[FW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    if (rounded[MAN_W+1]) begin
      rounded = rounded >> 1;
      exp_w   = exp_w + 10'd1;
    end
    if (cancel || exp_w[9] || exp_w == 10'd0 || !rounded[MAN_W])
      normal_sum = FP32_ZERO;
    else if (exp_w >= 10'd255)
      normal_sum = {l_sign, 8'hFF, 23'h0};
    else
      normal_sum = {l_sign, exp_w[7:0], rounded[MAN_W-1:0]};
  end

  always_comb begin
    sum = normal_sum;
    if (a_nan || b_nan)                        sum = FP32_QNAN;
    else if (a_inf && b_inf && a_sign != b_sign) sum = FP32_QNAN;
    else if (a_inf)                            sum = a;
    else if (b_inf)                            sum = b;
    else if (a_zero && b_zero)                 sum = FP32_ZERO;
    else if (a_zero)                           sum = b;
    else if (b_zero)                           sum = a;
  end
endmodule

// File: rtl/snn_synapse_mac.sv
// Per-neuron synaptic accumulator: lowest matching synapse slot adds its fp32 weight each cycle.
// Define MAC_EDGE_DETECT_EN to add only when source_address changes from the previous edge.
module snn_synapse_mac #(
  parameter int N_SYN  = mac_pkg::N_SYN,
  parameter int ADDR_W = mac_pkg::ADDR_W,
  parameter int DATA_W = mac_pkg::DATA_W
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [ADDR_W-1:0]        neuron_address,
  input  logic [ADDR_W-1:0]        source_address,
  input  logic [N_SYN*DATA_W-1:0]  weights_array,
  input  logic [N_SYN*ADDR_W-1:0]  source_addresses_array,
  input  logic                     clear,
  output logic [DATA_W-1:0]        result
);
  import mac_pkg::FP32_ZERO;

  localparam int IDX_W = (N_SYN > 1) ? $clog2(N_SYN) : 1;

  logic [N_SYN-1:0]  slot_hit;
  logic              hit, accept;
  logic [IDX_W-1:0]  hit_idx;
  logic [DATA_W-1:0] weight_sel, sum_next, result_reg;
  logic [ADDR_W-1:0] neuron_addr_reg;

  // Address 0 marks an empty slot, so it can never match.
  genvar gi;
  generate
    for (gi = 0; gi < N_SYN; gi++) begin : g_slot
      assign slot_hit[gi] = (source_addresses_array[gi*ADDR_W +: ADDR_W] != '0) &&
                            (source_addresses_array[gi*ADDR_W +: ADDR_W] == source_address);
    end
  endgenerate

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SYN - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign weight_sel = weights_array[hit_idx*DATA_W +: DATA_W];

  fp32_adder u_add (
    .a   (result_reg),
    .b   (weight_sel),
    .sum (sum_next)
  );

`ifdef MAC_EDGE_DETECT_EN
  logic [ADDR_W-1:0] prev_addr_reg;

  assign accept = hit && (source_address != prev_addr_reg);

  always_ff @(posedge CLK) begin
    if (RESET || clear) prev_addr_reg <= '0;
    else                prev_addr_reg <= source_address;
  end
`else
  assign accept = hit;
`endif

  always_ff @(posedge CLK) begin
    if (RESET)       result_reg <= FP32_ZERO;
    else if (clear)  result_reg <= FP32_ZERO;
    else if (accept) result_reg <= sum_next;
  end

  always_ff @(posedge CLK) begin
    if (RESET) neuron_addr_reg <= '0;
    else       neuron_addr_reg <= neuron_address;
  end

  assign result = result_reg;
endmodule

// File: tb/tb_snn_synapse_mac.sv
// Bench for snn_synapse_mac: directed steps then random traffic against an exact-arithmetic fp32 model.
module tb_snn_synapse_mac;
  import mac_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                    RESET, clear;
  logic [ADDR_W-1:0]       neuron_address, source_address;
  logic [ADDR_W-1:0]       tbl [N_SYN];
  logic [DATA_W-1:0]       wt  [N_SYN];
  logic [N_SYN*DATA_W-1:0] weights_array;
  logic [N_SYN*ADDR_W-1:0] source_addresses_array;
  logic [DATA_W-1:0]       result;

  logic [31:0] model_res, held;
  logic [11:0] model_prev;
  int total = 0;
  int passed = 0;

  always_comb begin
    weights_array          = '0;
    source_addresses_array = '0;
    for (int i = 0; i < N_SYN; i++) begin
      weights_array[i*DATA_W +: DATA_W]          = wt[i];
      source_addresses_array[i*ADDR_W +: ADDR_W] = tbl[i];
    end
  end

  snn_synapse_mac dut (
    .CLK                    (CLK),
    .RESET                  (RESET),
    .neuron_address         (neuron_address),
    .source_address         (source_address),
    .weights_array          (weights_array),
    .source_addresses_array (source_addresses_array),
    .clear                  (clear),
    .result                 (result)
  );

  // Exact sum as a wide integer scaled by 2^(emin-150), then one RNE rounding to 24 bits.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [299:0] ma, mb, mag, keep, rem, half;
    int ea, eb, emin, p, sh, be;
    logic sa, sb, sgn;
    sa = a[31]; ea = int'(a[30:23]);
    sb = b[31]; eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return FP32_QNAN;
    if (ea == 255 && eb == 255) return (sa == sb) ? a : FP32_QNAN;
    if (ea == 255) return a;
    if (eb == 255) return b;
    if (ea == 0 && eb == 0) return 32'h0;
    if (ea == 0) return b;
    if (eb == 0) return a;
    emin = (ea < eb) ? ea : eb;
    ma = 300'({1'b1, a[22:0]}) << (ea - emin);
    mb = 300'({1'b1, b[22:0]}) << (eb - emin);
    if (sa == sb)      begin mag = ma + mb; sgn = sa; end
    else if (ma >= mb) begin mag = ma - mb; sgn = sa; end
    else               begin mag = mb - ma; sgn = sb; end
    if (mag == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    be = p + emin - 23;
    if (p > 23) begin
      sh   = p - 23;
      keep = mag >> sh;
      rem  = mag - (keep << sh);
      half = 300'(1) << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 1;
      if (keep[24]) begin keep = keep >> 1; be++; end
    end else begin
      keep = mag << (23 - p);
    end
    if (be >= 255) return {sgn, 8'hFF, 23'h0};
    if (be <= 0) return 32'h0;
    return {sgn, 8'(be), keep[22:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_ulp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    logic [31:0] d;
    d = (obs > exp) ? obs - exp : exp - obs;
    total++;
    assert (d <= 32'd1) passed++;
    else $error("FAIL %s: observed=%h expected=%h (+-1 ulp)", tag, obs, exp);
  endtask

  // Advance the model by one edge from the current inputs, clock the DUT, compare.
  task automatic cycle(input string tag);
    int idx;
    logic take;
    idx = -1;
    for (int i = 0; i < N_SYN; i++)
      if (idx < 0 && tbl[i] != 0 && tbl[i] == source_address) idx = i;
    if (RESET || clear) begin
      model_res  = 32'h0;
      model_prev = '0;
    end else begin
      take = (idx >= 0);
`ifdef MAC_EDGE_DETECT_EN
      take = take && (source_address != model_prev);
`endif
      model_prev = source_address;
      if (take) model_res = ref_add(model_res, wt[idx]);
    end
    @(posedge CLK);
    #1;
    $display("%s rst=%0b clr=%0b src=%0d result=%h model=%h", tag, RESET, clear,
             source_address, result, model_res);
    check(tag, result, model_res);
  endtask

  function automatic logic [31:0] rand_w();
    int r;
    r = $urandom_range(0, 99);
    if (r < 3) return 32'h0;
    if (r < 5) return {1'($urandom_range(0, 1)), 8'hFF, 23'h0};
    if (r < 6) return 32'h7F80_0001;
    if (r < 8) return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom_range(1, 1000))};
    if (r < 12) return {~model_res[31], model_res[30:0]};
    return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 150)), 23'($urandom)};
  endfunction

  task automatic load_demo_table();
    tbl[4] = 12'd3; wt[4] = 32'h4290_B333;
    tbl[3] = 12'd4; wt[3] = 32'h4197_5C29;
    tbl[2] = 12'd5; wt[2] = 32'h4247_0A3D;
    tbl[1] = 12'd6; wt[1] = 32'h0000_0000;
    tbl[0] = 12'd7; wt[0] = 32'h42AE_3852;
  endtask

  initial begin
    model_res = 32'h0;
    model_prev = '0;
    neuron_address = 12'd42;
    clear = 1'b0;
    RESET = 1'b1;
    source_address = 12'($urandom);
    for (int i = 0; i < N_SYN; i++) begin
      tbl[i] = 12'($urandom);
      wt[i]  = 32'($urandom);
    end
    cycle("reset_any");
    check("reset_zero", result, 32'h0);

    load_demo_table();
    source_address = 12'd3;
    cycle("reset_with_hit");
    check("reset_with_hit_zero", result, 32'h0);

    RESET = 1'b0;
    source_address = 12'd3; cycle("acc_3");
    check("acc_3_const", result, 32'h4290_B333);
    source_address = 12'd4; cycle("acc_4");
    source_address = 12'd5; cycle("acc_5");
    source_address = 12'd7; cycle("acc_7");
    check_ulp("acc_final_const", result, 32'h4364_23D7);

    held = result;
    source_address = 12'd6; cycle("zero_weight");
    source_address = 12'd9; cycle("no_match");
    source_address = 12'd0; cycle("addr_zero");
    check("unchanged", result, held);

    clear = 1'b1; source_address = 12'd3; cycle("clear_with_hit");
    check("clear_zero", result, 32'h0);
    clear = 1'b0; cycle("after_clear_3");
    check("after_clear_const", result, 32'h4290_B333);

    clear = 1'b1; source_address = 12'd0; cycle("clear_dup");
    clear = 1'b0;
    tbl[1] = 12'd5; wt[1] = 32'h4000_0000;
    tbl[0] = 12'd5; wt[0] = 32'h3F80_0000;
    source_address = 12'd5; cycle("dup_slot");
    check("dup_lowest_slot", result, 32'h3F80_0000);

    load_demo_table();
    clear = 1'b1; source_address = 12'd0; cycle("clear_hold");
    clear = 1'b0; source_address = 12'd3;
    cycle("hold_1");
    cycle("hold_2");
    cycle("hold_3");
`ifdef MAC_EDGE_DETECT_EN
    check("hold_once", result, 32'h4290_B333);
`endif

    for (int n = 0; n < 300; n++) begin
      if (n % 16 == 0)
        for (int i = 0; i < N_SYN; i++) begin
          tbl[i] = 12'($urandom_range(0, 7));
          wt[i]  = rand_w();
        end
      else if ($urandom_range(0, 3) == 0)
        wt[$urandom_range(0, N_SYN - 1)] = rand_w();
      source_address = 12'($urandom_range(0, 8));
      clear = ($urandom_range(0, 9) == 0);
      RESET = ($urandom_range(0, 49) == 0);
      neuron_address = 12'($urandom);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
